// File: rtl/mem_wb_stage.sv
// MEM/WB elastic pipeline register: main + skid entry, valid/ready handshake, sync flush, stall counter.
// One-cycle latency; in_ready is registered and drops only when the skid entry is occupied.
module mem_wb_stage #(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_ADDR_W-1:0]  write_address_in,
    input  logic                   write_en_in,
    input  logic                   mux5_sel_in,
    input  logic [XLEN-1:0]        alu_result_in,
    input  logic [XLEN-1:0]        d_mem_result_in,
    input  logic                   mem_read_in,
    input  logic [REG_ADDR_W-1:0]  reg1_read_address_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REG_ADDR_W-1:0]  write_address_out,
    output logic                   write_en_out,
    output logic                   mux5_sel_out,
    output logic [XLEN-1:0]        alu_result_out,
    output logic [XLEN-1:0]        d_mem_result_out,
    output logic                   mem_read_out,
    output logic [REG_ADDR_W-1:0]  reg1_read_address_out,
    output logic [XLEN-1:0]        wb_data_out,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic                  we;
        logic                  sel;
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       dmem;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] rs1;
    } bundle_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_in_ready;
    bundle_t                r_main;
    bundle_t                r_skid;
    bundle_t                w_in;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_out_valid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load_main;
    logic                   w_load_skid;
    logic                   w_skid_to_main;

    assign w_in = '{waddr: write_address_in, we: write_en_in, sel: mux5_sel_in,
                    alu: alu_result_in, dmem: d_mem_result_in,
                    mem_read: mem_read_in, rs1: reg1_read_address_in};

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_push      = in_valid & r_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) begin
                    w_load_main = 1'b1;
                    w_state_nxt = S_ONE;
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_main = 1'b1;
                    end else if (w_push) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = S_TWO;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: if (w_pop) begin
                    w_skid_to_main = 1'b1;
                    w_state_nxt    = S_ONE;
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_in;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in;
            end
        end
    end

    // Saturating: holds at all-ones until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign in_ready              = r_in_ready;
    assign out_valid             = w_out_valid;
    assign write_address_out     = r_main.waddr;
    assign write_en_out          = w_out_valid & r_main.we;
    assign mux5_sel_out          = r_main.sel;
    assign alu_result_out        = r_main.alu;
    assign d_mem_result_out      = r_main.dmem;
    assign mem_read_out          = w_out_valid & r_main.mem_read;
    assign reg1_read_address_out = r_main.rs1;
    assign wb_data_out           = r_main.sel ? r_main.dmem : r_main.alu;
    assign stall_count           = r_stall_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (STALL_CNT_W=3 so saturation is reachable quickly).
module tb_mem_wb_stage;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int SCW  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [RAW-1:0]  write_address_in;
    logic            write_en_in;
    logic            mux5_sel_in;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] d_mem_result_in;
    logic            mem_read_in;
    logic [RAW-1:0]  reg1_read_address_in;
    logic            out_valid;
    logic            out_ready;
    logic [RAW-1:0]  write_address_out;
    logic            write_en_out;
    logic            mux5_sel_out;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] d_mem_result_out;
    logic            mem_read_out;
    logic [RAW-1:0]  reg1_read_address_out;
    logic [XLEN-1:0] wb_data_out;
    logic [SCW-1:0]  stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .write_address_in(write_address_in), .write_en_in(write_en_in),
        .mux5_sel_in(mux5_sel_in), .alu_result_in(alu_result_in),
        .d_mem_result_in(d_mem_result_in), .mem_read_in(mem_read_in),
        .reg1_read_address_in(reg1_read_address_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .write_address_out(write_address_out), .write_en_out(write_en_out),
        .mux5_sel_out(mux5_sel_out), .alu_result_out(alu_result_out),
        .d_mem_result_out(d_mem_result_out), .mem_read_out(mem_read_out),
        .reg1_read_address_out(reg1_read_address_out),
        .wb_data_out(wb_data_out), .stall_count(stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [RAW-1:0] a, input logic we, input logic sel,
                          input logic [XLEN-1:0] alu, input logic [XLEN-1:0] dm,
                          input logic mr, input logic [RAW-1:0] rs1);
        in_valid = v; write_address_in = a; write_en_in = we; mux5_sel_in = sel;
        alu_result_in = alu; d_mem_result_in = dm; mem_read_in = mr; reg1_read_address_in = rs1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (stall_count !== 3'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
        checks++; if (wb_data_out !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data_out); end
        reset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_single_load();
        out_ready = 1'b1;
        set_in(1'b1, 5'd5, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 5'd3);
        step();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b exp 1", out_valid); end
        checks++; if (write_en_out !== 1'b1) begin errors++; $display("FAIL load_we got %b exp 1", write_en_out); end
        checks++; if (wb_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL load_wb_data got %h exp deadbeef", wb_data_out); end
        checks++; if (write_address_out !== 5'd5) begin errors++; $display("FAIL load_waddr got %0d exp 5", write_address_out); end
        checks++; if (mem_read_out !== 1'b1) begin errors++; $display("FAIL load_mem_read got %b exp 1", mem_read_out); end
        checks++; if (reg1_read_address_out !== 5'd3) begin errors++; $display("FAIL load_rs1 got %0d exp 3", reg1_read_address_out); end
        checks++; if (alu_result_out !== 32'h100) begin errors++; $display("FAIL load_alu got %h exp 100", alu_result_out); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_drain_valid got %b exp 0", out_valid); end
        checks++; if (write_en_out !== 1'b0) begin errors++; $display("FAIL load_drain_we got %b exp 0", write_en_out); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        set_in(1'b1, 5'd1, 1'b1, 1'b0, 32'h1, 32'hA1, 1'b0, 5'd0);
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got %b exp 1", in_ready); end
        checks++; if (alu_result_out !== 32'h1) begin errors++; $display("FAIL bp_head_a got %h exp 1", alu_result_out); end
        set_in(1'b1, 5'd2, 1'b1, 1'b0, 32'h2, 32'hB2, 1'b0, 5'd0);
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b got %b exp 0", in_ready); end
        set_in(1'b1, 5'd3, 1'b1, 1'b0, 32'h3, 32'hC3, 1'b0, 5'd0);
        step();
        checks++; if (alu_result_out !== 32'h1) begin errors++; $display("FAIL bp_hold_a got %h exp 1", alu_result_out); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_blocked got %b exp 0", in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || alu_result_out !== 32'h2) begin errors++; $display("FAIL bp_head_b got %b/%h exp 1/2", out_valid, alu_result_out); end
        checks++; if (wb_data_out !== 32'h2) begin errors++; $display("FAIL bp_wb_b got %h exp 2", wb_data_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
        step();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (out_valid !== 1'b1 || alu_result_out !== 32'h3) begin errors++; $display("FAIL bp_head_c got %b/%h exp 1/3", out_valid, alu_result_out); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", out_valid); end
    endtask

    task automatic test_push_pop_one();
        out_ready = 1'b0;
        set_in(1'b1, 5'd7, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 5'd0);
        step();
        out_ready = 1'b1;
        set_in(1'b1, 5'd8, 1'b0, 1'b1, 32'h20, 32'h55, 1'b1, 5'd9);
        step();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (alu_result_out !== 32'h20 || write_address_out !== 5'd8) begin errors++; $display("FAIL pp_head_b got %h/%0d exp 20/8", alu_result_out, write_address_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_ready got %b exp 1", in_ready); end
        checks++; if (write_en_out !== 1'b0 || wb_data_out !== 32'h55) begin errors++; $display("FAIL pp_fields got %b/%h exp 0/55", write_en_out, wb_data_out); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_skid_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 5'd1, 1'b1, 1'b0, 32'hA, 32'h0, 1'b1, 5'd0);
        step();
        set_in(1'b1, 5'd2, 1'b1, 1'b0, 32'hB, 32'h0, 1'b1, 5'd0);
        step();
        flush = 1'b1;
        set_in(1'b1, 5'd4, 1'b1, 1'b1, 32'hD, 32'hD0, 1'b1, 5'd0);
        step();
        flush = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        checks++; if (write_en_out !== 1'b0 || mem_read_out !== 1'b0) begin errors++; $display("FAIL flush_gated got %b/%b exp 0/0", write_en_out, mem_read_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_d_leak got %b exp 0", out_valid); end
        out_ready = 1'b0;
        set_in(1'b1, 5'd1, 1'b1, 1'b0, 32'hE, 32'h0, 1'b0, 5'd0);
        step();
        flush = 1'b1;
        set_in(1'b1, 5'd6, 1'b1, 1'b0, 32'hF, 32'h0, 1'b0, 5'd0);
        step();
        flush = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_push_dropped got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid_traffic();
        out_ready = 1'b0;
        set_in(1'b1, 5'd9, 1'b1, 1'b1, 32'h11, 32'h22, 1'b1, 5'd4);
        step();
        set_in(1'b1, 5'd10, 1'b1, 1'b0, 32'h33, 32'h44, 1'b1, 5'd5);
        step();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_hs got %b/%b exp 0/1", out_valid, in_ready); end
        checks++; if (stall_count !== 3'd0) begin errors++; $display("FAIL rst_mid_stall got %0d exp 0", stall_count); end
        checks++; if (write_en_out !== 1'b0 || mem_read_out !== 1'b0 || wb_data_out !== 32'h0) begin errors++; $display("FAIL rst_mid_gated got %b/%b/%h exp 0/0/0", write_en_out, mem_read_out, wb_data_out); end
        checks++; if (write_address_out !== 5'd0 || reg1_read_address_out !== 5'd0 || alu_result_out !== 32'h0 || d_mem_result_out !== 32'h0 || mux5_sel_out !== 1'b0) begin errors++; $display("FAIL rst_mid_payload got %0d/%0d/%h/%h/%b exp all 0", write_address_out, reg1_read_address_out, alu_result_out, d_mem_result_out, mux5_sel_out); end
        step();
        reset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release got %b/%b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_stall_saturation();
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 5'd1, 1'b1, 1'b0, 32'h77, 32'h0, 1'b0, 5'd0);
        step();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        checks++; if (stall_count !== 3'd0) begin errors++; $display("FAIL sat_start got %0d exp 0", stall_count); end
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (stall_count !== SCW'((i > 7) ? 7 : i)) begin
                errors++; $display("FAIL sat_cycle_%0d got %0d exp %0d", i, stall_count, (i > 7) ? 7 : i);
            end
        end
        out_ready = 1'b1;
        step();
        checks++; if (stall_count !== 3'd7 || out_valid !== 1'b0) begin errors++; $display("FAIL sat_hold got %0d/%b exp 7/0", stall_count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_back_pressure();
        test_push_pop_one();
        test_flush();
        test_reset_mid_traffic();
        test_stall_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
